// File: rtl/sprite_pkg.sv
// Shared constants and pipeline tag types for the two-player sprite ROM arbiter.
package sprite_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 12;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    typedef logic tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } pipe_ent_t;

endpackage

// File: rtl/sprite_tag_pipe.sv
// Delay line carrying {valid, tag} alongside the external ROM so responses can be
// steered to the requesting player when the ROM word arrives.
module sprite_tag_pipe
    import sprite_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst_l,
    input  pipe_ent_t in_ent,
    output pipe_ent_t out_ent
);

    pipe_ent_t stage_q [DEPTH];
    pipe_ent_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = in_ent;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign out_ent = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Two-player arbiter in front of a shared external sprite ROM (round-robin by default).
// Define SPRITE_ARB_FIXED_PRIO_EN to make player 1 always win contention.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              arb_en,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data
);

    logic              grant_vld;
    tag_t              grant_idx;
    logic              contend_pick;

    logic              rom_en_q,   rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    tag_t              rom_tag_q,  rom_tag_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

    pipe_ent_t         pipe_in;
    pipe_ent_t         pipe_out;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    assign contend_pick = P1;
`else
    tag_t last_grant_q, last_grant_d;

    // Reset value P2 means player 1 wins the first contention.
    assign contend_pick = ~last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_vld) begin
            last_grant_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            last_grant_q <= P2;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = P1;
        if (rst_l && arb_en) begin
            case (req_valid)
                2'b01: begin
                    grant_vld = 1'b1;
                    grant_idx = P1;
                end
                2'b10: begin
                    grant_vld = 1'b1;
                    grant_idx = P2;
                end
                2'b11: begin
                    grant_vld = 1'b1;
                    grant_idx = contend_pick;
                end
                default: begin
                    grant_vld = 1'b0;
                    grant_idx = P1;
                end
            endcase
        end
    end

    // A grant implies the requester is valid, so ready high is always an accept.
    always_comb begin
        req_ready = 2'b00;
        if (grant_vld) begin
            req_ready = (grant_idx == P2) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        rom_en_d   = grant_vld;
        rom_addr_d = rom_addr_q;
        rom_tag_d  = rom_tag_q;
        if (grant_vld) begin
            rom_addr_d = (grant_idx == P2) ? req_addr1 : req_addr0;
            rom_tag_d  = grant_idx;
        end
    end

    assign pipe_in = '{valid: rom_en_q, tag: rom_tag_q};

    sprite_tag_pipe #(
        .DEPTH (ROM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_l   (rst_l),
        .in_ent  (pipe_in),
        .out_ent (pipe_out)
    );

    always_comb begin
        rsp_valid_d = 2'b00;
        rsp_data_d  = rsp_data_q;
        if (pipe_out.valid) begin
            rsp_valid_d = (pipe_out.tag == P2) ? 2'b10 : 2'b01;
            rsp_data_d  = rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_tag_q   <= P1;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
        end else begin
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            rom_tag_q   <= rom_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
